tausworthe_checker: RTL and testbench
=====================================

# tausworthe_checker

Stream checker for the three-component Tausworthe uniform generator. It regenerates the expected 32-bit sequence locally from the same seeds and compares it word-by-word against the incoming `valid`-qualified stream. It counts mismatches and raises a sticky alarm when the stream loses sync. It sits at the consumer end of the URNG link in the AWGN datapath, or in the bench as a self-check.

## Interface
- `SEED0`, default 32'hfffff0f0: component-0 seed; must match the generator.
- `SEED1`, default 32'hccccc0c0: component-1 seed.
- `SEED2`, default 32'hffff0000: component-2 seed.
- `ALARM_LIMIT`, default 4: consecutive mismatches that trigger alarm; range 1..255.
- `CNT_W`, default 16: width of the error and word counters.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears everything.
- `restart` in 1: synchronous; reloads seeds and clears counters and alarm.
- `data_in` in 32: word from the generator.
- `valid_in` in 1: `data_in` is a new sample this cycle.
- `expected_out` out 32: expected word for the most recently checked sample.
- `error_pulse` out 1: one-cycle high when the checked word mismatched.
- `error_count` out CNT_W: total mismatches, saturating.
- `word_count` out CNT_W: total words checked, saturating.
- `locked` out 1: at least one word checked and no alarm.
- `alarm` out 1: sticky loss-of-sync flag.

## Operation
- Internal state S0/S1/S2 (96 bits) and the step function are identical to the generator's:
  - S0' = ((S0 & fffffffe) << 12) ^ (((S0 << 13) ^ S0) >> 19)
  - S1' = ((S1 & fffffff8) << 4) ^ (((S1 << 2) ^ S1) >> 25)
  - S2' = ((S2 & fffffff0) << 17) ^ (((S2 << 3) ^ S2) >> 11)
  - All arithmetic is 32-bit unsigned; logical shifts; bits shifted out are dropped.
- On reset or restart, S loads {SEED0, SEED1, SEED2}. The generator's first valid word is the XOR of the once-stepped seeds.
- On each cycle with `valid_in`=1 (and `restart`=0):
  - exp = S0' ^ S1' ^ S2'.
  - S <= S'.
  - Compare `data_in` with exp.
- The checker advances exactly one step per valid word, whether the word matched or not. There is no resync search; recovery is via `restart` only.
- Consecutive-mismatch counter (8 bits, internal):
  - increments on a mismatch; clears on a match;
  - saturates at 255.
- FSM:
  - IDLE (after reset/restart, no word checked yet): first valid word goes to TRACK, or to ALARM if ALARM_LIMIT=1 and the word mismatched.
  - TRACK: goes to ALARM when the consecutive-mismatch count reaches ALARM_LIMIT.
  - ALARM: sticky; leaves only on `restart` (to IDLE) or `reset`.
  - Checking, counting and stepping continue in ALARM.
- Derived flags: `locked` = (state==TRACK); `alarm` = (state==ALARM).
- `error_count` and `word_count` saturate at 2^CNT_W-1 and never wrap.

## Timing
- Latency is 1 cycle. The word sampled at edge k drives `expected_out`, `error_pulse`, the counters and the state flags after edge k.
- `error_pulse` is high for exactly one cycle per mismatching valid word. Back-to-back mismatches give continuous high.
- Idle cycles (`valid_in`=0):
  - S and counters hold;
  - `error_pulse` returns to 0;
  - `expected_out` holds.
- `restart` takes priority over `valid_in` in the same cycle; that word is discarded, not checked.
- Reset values: all outputs 0, S = seeds, FSM = IDLE.
- Reset asserted mid-stream takes effect immediately, whatever `valid_in` is doing.
- `valid_in` may be high every cycle; there is no backpressure.

## Structure
- Shared package `urng_pkg`:
  - seed constants;
  - the three mask/shift constants per component;
  - the FSM state enum (IDLE, TRACK, ALARM).
- Sub-module `taus_step`: combinational, 96-bit state in, 96-bit next state and 32-bit XOR output. The generator is to be refactored to use it as well, so the two ends cannot diverge.
- The checker contains only registers, the compare, the counters and the FSM.

## Test plan
- Generator → checker, 1000 consecutive valid words: `error_count`=0, `word_count`=1000, `locked`=1 from the cycle after the first word, `alarm`=0, `expected_out`==`data_in` of the previous cycle throughout.
- Flip bit 0 of word 10 only: one `error_pulse` one cycle after that word, `error_count`=1, `locked` stays 1, words 11+ match.
- Corrupt words 20–23 (ALARM_LIMIT=4):
  - `alarm` rises one cycle after word 23, `locked` falls;
  - uncorrupted later words keep `alarm`=1 and `error_count`=4.
- Drop one generator word at word 50 (checker falls out of step):
  - every subsequent word mismatches;
  - `alarm` one cycle after word 53;
  - `restart`, then restarting the generator from reset, gives `locked` again with counters at 0.
- CNT_W=4, 20 forced mismatches: `error_count` saturates at 15, with no wrap.
- Assert `restart` and `valid_in` in the same cycle: that word is not counted, and the next valid word is checked against the first post-seed word. Then pulse `reset` mid-stream: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/urng_pkg.sv
// Shared constants and types for the three-component Tausworthe URNG
// generator and its stream checker.
package urng_pkg;

    // Default component seeds; generator and checker must agree on these.
    localparam logic [31:0] SEED0_DEF = 32'hfffff0f0;
    localparam logic [31:0] SEED1_DEF = 32'hccccc0c0;
    localparam logic [31:0] SEED2_DEF = 32'hffff0000;

    // Per component: S' = ((S & MASK) << SH_A) ^ (((S << SH_B) ^ S) >> SH_C)
    localparam logic [31:0] C0_MASK = 32'hfffffffe;
    localparam int unsigned C0_SH_A = 12;
    localparam int unsigned C0_SH_B = 13;
    localparam int unsigned C0_SH_C = 19;

    localparam logic [31:0] C1_MASK = 32'hfffffff8;
    localparam int unsigned C1_SH_A = 4;
    localparam int unsigned C1_SH_B = 2;
    localparam int unsigned C1_SH_C = 25;

    localparam logic [31:0] C2_MASK = 32'hfffffff0;
    localparam int unsigned C2_SH_A = 17;
    localparam int unsigned C2_SH_B = 3;
    localparam int unsigned C2_SH_C = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ALARM = 2'd2
    } chk_state_e;

    // One Tausworthe component step; 32-bit logical shifts, overflow dropped.
    function automatic logic [31:0] taus_comp(input logic [31:0] s,
                                              input logic [31:0] mask,
                                              input int unsigned sh_a,
                                              input int unsigned sh_b,
                                              input int unsigned sh_c);
        return ((s & mask) << sh_a) ^ (((s << sh_b) ^ s) >> sh_c);
    endfunction

endpackage

// File: rtl/taus_step.sv
// Combinational Tausworthe step: 96-bit state {S0,S1,S2} in, next state and
// the XOR of the stepped components out. Shared by generator and checker.
module taus_step
    import urng_pkg::*;
(
    input  logic [95:0] i_state,
    output logic [95:0] o_next,
    output logic [31:0] o_word
);
    logic [31:0] w_s0;
    logic [31:0] w_s1;
    logic [31:0] w_s2;

    // Step each component independently, then combine.
    always_comb begin
        w_s0   = taus_comp(i_state[95:64], C0_MASK, C0_SH_A, C0_SH_B, C0_SH_C);
        w_s1   = taus_comp(i_state[63:32], C1_MASK, C1_SH_A, C1_SH_B, C1_SH_C);
        w_s2   = taus_comp(i_state[31:0],  C2_MASK, C2_SH_A, C2_SH_B, C2_SH_C);
        o_next = {w_s0, w_s1, w_s2};
        o_word = w_s0 ^ w_s1 ^ w_s2;
    end
endmodule

// File: rtl/tausworthe_checker.sv
// Tausworthe stream checker: regenerates the expected sequence from the
// seeds, compares each valid word, counts errors and flags loss of sync.
module tausworthe_checker
    import urng_pkg::*;
#(
    parameter logic [31:0] SEED0       = SEED0_DEF,
    parameter logic [31:0] SEED1       = SEED1_DEF,
    parameter logic [31:0] SEED2       = SEED2_DEF,
    parameter int          ALARM_LIMIT = 4,
    parameter int          CNT_W       = 16
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             restart,
    input  logic [31:0]      data_in,
    input  logic             valid_in,
    output logic [31:0]      expected_out,
    output logic             error_pulse,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] word_count,
    output logic             locked,
    output logic             alarm
);
    localparam logic [95:0] SEEDS     = {SEED0, SEED1, SEED2};
    localparam logic [7:0]  LIMIT8    = 8'(ALARM_LIMIT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [95:0]      r_s;
    logic [31:0]      r_exp;
    logic             r_pulse;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] r_words;
    logic [7:0]       r_consec;
    chk_state_e       r_state;

    logic [95:0]      w_next;
    logic [31:0]      w_word;
    logic             w_mismatch;
    logic [7:0]       w_consec_nxt;
    chk_state_e       w_state_nxt;

    taus_step u_step (
        .i_state (r_s),
        .o_next  (w_next),
        .o_word  (w_word)
    );

    // Compare and the saturating consecutive-mismatch count this word would produce.
    always_comb begin
        w_mismatch   = (data_in != w_word);
        w_consec_nxt = 8'd0;
        if (w_mismatch)
            w_consec_nxt = (r_consec == 8'hff) ? 8'hff : r_consec + 8'd1;
    end

    // Next-state logic: IDLE and TRACK share the threshold test; ALARM is sticky.
    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = ST_IDLE;
        end else if (valid_in) begin
            case (r_state)
                ST_IDLE, ST_TRACK:
                    w_state_nxt = (w_consec_nxt >= LIMIT8) ? ST_ALARM : ST_TRACK;
                ST_ALARM:
                    w_state_nxt = ST_ALARM;
                default:
                    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Datapath: generator state, result registers and saturating counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s      <= SEEDS;
            r_exp    <= '0;
            r_pulse  <= 1'b0;
            r_err    <= '0;
            r_words  <= '0;
            r_consec <= '0;
        end else if (restart) begin
            r_s      <= SEEDS;
            r_exp    <= '0;
            r_pulse  <= 1'b0;
            r_err    <= '0;
            r_words  <= '0;
            r_consec <= '0;
        end else if (valid_in) begin
            r_s      <= w_next;
            r_exp    <= w_word;
            r_pulse  <= w_mismatch;
            r_consec <= w_consec_nxt;
            if (r_words != '1)
                r_words <= r_words + ONE;
            if (w_mismatch && (r_err != '1))
                r_err <= r_err + ONE;
        end else begin
            r_pulse  <= 1'b0;
        end
    end

    assign expected_out = r_exp;
    assign error_pulse  = r_pulse;
    assign error_count  = r_err;
    assign word_count   = r_words;
    assign locked       = (r_state == ST_TRACK);
    assign alarm        = (r_state == ST_ALARM);

endmodule

// File: tb/tb_tausworthe_checker.sv
// Self-checking bench for tausworthe_checker: a bench-side generator feeds the
// DUT, a behavioural model fills a scoreboard queue, and outputs are compared
// one cycle later. A second instance with CNT_W=4 sees inverted data.
module tb_tausworthe_checker;

    localparam logic [95:0] SEEDS = {32'hfffff0f0, 32'hccccc0c0, 32'hffff0000};

    logic        clock = 1'b0;
    logic        reset;
    logic        restart;
    logic [31:0] data_in;
    logic        valid_in;
    logic [31:0] data_inv;

    logic [31:0] expected_out, expected_out2;
    logic        error_pulse, error_pulse2;
    logic [15:0] error_count, word_count;
    logic [3:0]  error_count2, word_count2;
    logic        locked, alarm, locked2, alarm2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;
    assign data_inv = ~data_in;

    tausworthe_checker dut (
        .clock(clock), .reset(reset), .restart(restart),
        .data_in(data_in), .valid_in(valid_in),
        .expected_out(expected_out), .error_pulse(error_pulse),
        .error_count(error_count), .word_count(word_count),
        .locked(locked), .alarm(alarm)
    );

    tausworthe_checker #(.CNT_W(4)) dut2 (
        .clock(clock), .reset(reset), .restart(restart),
        .data_in(data_inv), .valid_in(valid_in),
        .expected_out(expected_out2), .error_pulse(error_pulse2),
        .error_count(error_count2), .word_count(word_count2),
        .locked(locked2), .alarm(alarm2)
    );

    // Reference step written straight from the recurrence.
    function automatic logic [95:0] tstep(input logic [95:0] s);
        logic [31:0] a, b, c;
        a = s[95:64]; b = s[63:32]; c = s[31:0];
        a = ((a & 32'hfffffffe) << 12) ^ (((a << 13) ^ a) >> 19);
        b = ((b & 32'hfffffff8) << 4)  ^ (((b << 2)  ^ b) >> 25);
        c = ((c & 32'hfffffff0) << 17) ^ (((c << 3)  ^ c) >> 11);
        return {a, b, c};
    endfunction

    // Bench-side generator.
    logic [95:0] g_s;
    function automatic logic [31:0] gen_word();
        g_s = tstep(g_s);
        return g_s[95:64] ^ g_s[63:32] ^ g_s[31:0];
    endfunction

    // Checker model.
    logic [95:0] m_s;
    logic [31:0] m_exp;
    logic        m_p, m_p2;
    int          m_e, m_w, m_e2, m_w2, m_c, m_st;

    typedef struct {
        logic [31:0] exp;
        logic        pulse;
        int          ecnt, wcnt;
        logic        lk, al;
        logic        pulse2;
        int          ecnt2, wcnt2;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_s = SEEDS; m_exp = '0; m_p = 0; m_p2 = 0;
        m_e = 0; m_w = 0; m_e2 = 0; m_w2 = 0; m_c = 0; m_st = 0;
    endtask

    task automatic check_zero();
        check("rst_exp", expected_out, 32'h0);
        check("rst_pulse", 32'(error_pulse), 32'h0);
        check("rst_ecnt", 32'(error_count), 32'h0);
        check("rst_wcnt", 32'(word_count), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_alarm", 32'(alarm), 32'h0);
        check("rst_ecnt2", 32'(error_count2), 32'h0);
        check("rst_exp2", expected_out2, 32'h0);
    endtask

    // Drive one cycle, push the model's prediction, pop and compare after the edge.
    task automatic drive(input bit v, input bit rs, input logic [31:0] d);
        exp_t e;
        bit   mm, mm2;
        if (rs) begin
            model_reset();
        end else if (v) begin
            m_s   = tstep(m_s);
            m_exp = m_s[95:64] ^ m_s[63:32] ^ m_s[31:0];
            mm    = (d != m_exp);
            mm2   = (~d != m_exp);
            m_p   = mm; m_p2 = mm2;
            if (m_w < 65535) m_w++;
            if (mm && m_e < 65535) m_e++;
            if (m_w2 < 15) m_w2++;
            if (mm2 && m_e2 < 15) m_e2++;
            m_c = mm ? ((m_c < 255) ? m_c + 1 : 255) : 0;
            if (m_st != 2) m_st = (m_c >= 4) ? 2 : 1;
        end else begin
            m_p = 0; m_p2 = 0;
        end
        e.exp = m_exp; e.pulse = m_p; e.ecnt = m_e; e.wcnt = m_w;
        e.lk = (m_st == 1); e.al = (m_st == 2);
        e.pulse2 = m_p2; e.ecnt2 = m_e2; e.wcnt2 = m_w2;
        sb.push_back(e);

        valid_in = v; restart = rs; data_in = d;
        @(posedge clock); #1;

        e = sb.pop_front();
        check("expected_out", expected_out, e.exp);
        check("error_pulse", 32'(error_pulse), 32'(e.pulse));
        check("error_count", 32'(error_count), 32'(e.ecnt));
        check("word_count", 32'(word_count), 32'(e.wcnt));
        check("locked", 32'(locked), 32'(e.lk));
        check("alarm", 32'(alarm), 32'(e.al));
        check("error_pulse2", 32'(error_pulse2), 32'(e.pulse2));
        check("error_count2", 32'(error_count2), 32'(e.ecnt2));
        check("word_count2", 32'(word_count2), 32'(e.wcnt2));
    endtask

    // Restart with a valid word in the same cycle; that word must be ignored.
    task automatic restart_all();
        drive(1'b1, 1'b1, 32'hdeadbeef);
        g_s = SEEDS;
        check("restart_wcnt", 32'(word_count), 32'h0);
    endtask

    // Stream n words; corrupt bit 0 of words lo..hi; skip one generator word at drop.
    task automatic run_words(input int n, input int lo, input int hi, input int drop);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = gen_word();
            if (i == drop) w = gen_word();
            if (i >= lo && i <= hi) w = w ^ 32'h1;
            drive(1'b1, 1'b0, w);
        end
    endtask

    typedef struct {
        bit v, bad;
        bit pulse, lk, al;
    } vec_t;
    vec_t tbl[10];

    initial begin
        logic [31:0] w;
        tbl[0] = '{0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 1, 0};
        tbl[2] = '{1, 1, 1, 1, 0};
        tbl[3] = '{0, 0, 0, 1, 0};
        tbl[4] = '{1, 0, 0, 1, 0};
        tbl[5] = '{1, 1, 1, 1, 0};
        tbl[6] = '{1, 1, 1, 1, 0};
        tbl[7] = '{1, 1, 1, 1, 0};
        tbl[8] = '{1, 1, 1, 0, 1};
        tbl[9] = '{1, 0, 0, 0, 1};

        reset = 1'b1; restart = 1'b0; valid_in = 1'b0; data_in = '0;
        g_s = SEEDS; model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_zero();
        reset = 1'b0;

        // Table: idle cycles, single error, four in a row to alarm, sticky alarm.
        for (int i = 0; i < 10; i++) begin
            w = 32'h0;
            if (tbl[i].v) w = gen_word() ^ (tbl[i].bad ? 32'h1 : 32'h0);
            drive(tbl[i].v, 1'b0, w);
            check("tbl_pulse", 32'(error_pulse), 32'(tbl[i].pulse));
            check("tbl_locked", 32'(locked), 32'(tbl[i].lk));
            check("tbl_alarm", 32'(alarm), 32'(tbl[i].al));
        end

        // 1000 clean words, then idle cycles.
        restart_all();
        run_words(1000, -1, -1, -1);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h12345678);
        check("clean_wcnt", 32'(word_count), 32'd1000);
        check("clean_ecnt", 32'(error_count), 32'd0);
        check("clean_locked", 32'(locked), 32'd1);
        check("sat_ecnt2", 32'(error_count2), 32'd15);
        check("sat_wcnt2", 32'(word_count2), 32'd15);

        // Single flipped word.
        restart_all();
        run_words(30, 10, 10, -1);
        check("flip_ecnt", 32'(error_count), 32'd1);
        check("flip_locked", 32'(locked), 32'd1);

        // Four consecutive corrupt words.
        restart_all();
        run_words(30, 20, 23, -1);
        check("burst_alarm", 32'(alarm), 32'd1);
        check("burst_ecnt", 32'(error_count), 32'd4);

        // Dropped word: out of step for good, then recover via restart.
        restart_all();
        run_words(60, -1, -1, 50);
        check("drop_alarm", 32'(alarm), 32'd1);
        check("drop_ecnt", 32'(error_count), 32'd10);
        restart_all();
        run_words(10, -1, -1, -1);
        check("recover_locked", 32'(locked), 32'd1);
        check("recover_ecnt", 32'(error_count), 32'd0);

        // Restart with valid, then the first post-seed word must match.
        restart_all();
        run_words(3, -1, -1, -1);
        check("post_restart_ecnt", 32'(error_count), 32'd0);
        check("post_restart_wcnt", 32'(word_count), 32'd3);

        // Asynchronous reset mid-stream with valid high.
        valid_in = 1'b1; data_in = gen_word();
        #2;
        reset = 1'b1;
        #1;
        check_zero();
        @(posedge clock); #1;
        reset = 1'b0;
        g_s = SEEDS; model_reset(); sb.delete();
        run_words(5, -1, -1, -1);
        check("after_reset_wcnt", 32'(word_count), 32'd5);
        drive(1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
